switch_capture_ctrl: RTL and testbench



---
 rtl/switch_ctrl_pkg.sv | 11 +
 rtl/switch_debounce_bit.sv | 30 +++
 rtl/switch_capture_ctrl.sv | 65 ++++++
 tb/tb_switch_capture_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/switch_ctrl_pkg.sv
// switch_ctrl_pkg: register addresses and edge-mode encodings for switch_capture_ctrl
package switch_ctrl_pkg;
    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_MASK = 2'd1,
        ADDR_MODE = 2'd2,
        ADDR_EDGE = 2'd3
    } addr_e;
    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;
endpackage

// File: rtl/switch_debounce_bit.sv
// switch_debounce_bit: two-flop synchroniser plus 3-sample tick debouncer for one switch,
// with rise/fall strobes valid in the cycle the stable level changes.
module switch_debounce_bit (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);
    logic s1, s2, stable_next;
    logic [1:0] hist;
    always_comb stable_next = (tick && hist[1] == hist[0] && hist[0] == s2) ? s2 : stable;
    assign rise = stable_next & ~stable;
    assign fall = ~stable_next & stable;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            hist   <= 2'b00;
            stable <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            hist   <= tick ? {hist[0], s2} : hist;
            stable <= stable_next;
        end
    end
endmodule

// File: rtl/switch_capture_ctrl.sv
// switch_capture_ctrl: Avalon-MM slave that debounces a switch bank and edge-captures it
// into maskable write-1-to-clear registers driving a level irq (readLatency = 1).
module switch_capture_ctrl
    import switch_ctrl_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int TICK_CYCLES = 50000,
    parameter int TICK_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);
    logic [TICK_W-1:0] count;
    logic tick, wr, unused_wdata;
    logic [WIDTH-1:0] stable, rise, fall, ev, mask, mode, edge_cap;
    logic [WIDTH-1:0] wdata, clr, mask_next, mode_next, edge_cap_next, sel;
    assign tick = count == TICK_W'(TICK_CYCLES - 1);
    assign wr = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .tick   (tick),
            .raw    (in_port[i]),
            .stable (stable[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end
    // ev uses the registered mode, so a same-cycle MODE write applies only to later events
    assign ev = (rise & (mode ~^ {WIDTH{EDGE_RISE}})) | (fall & (mode ~^ {WIDTH{EDGE_FALL}}));
    assign mask_next = (wr && address == ADDR_MASK) ? wdata : mask;
    assign mode_next = (wr && address == ADDR_MODE) ? wdata : mode;
    assign clr = (wr && address == ADDR_EDGE) ? wdata : '0;
    assign edge_cap_next = (edge_cap & ~clr) | ev;
    assign sel = address == ADDR_DATA ? stable :
                 address == ADDR_MASK ? mask :
                 address == ADDR_MODE ? mode : edge_cap;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            mask     <= '0;
            mode     <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            count    <= tick ? '0 : count + 1'b1;
            mask     <= mask_next;
            mode     <= mode_next;
            edge_cap <= edge_cap_next;
            irq      <= |(edge_cap_next & mask_next);
            readdata <= 32'(sel);
        end
    end
endmodule

// File: tb/tb_switch_capture_ctrl.sv
// tb_switch_capture_ctrl: directed bench with a read scoreboard for switch_capture_ctrl
// (TICK_CYCLES=4, so debounce ticks land on every 4th clock edge after reset release).
module tb_switch_capture_ctrl;
    import switch_ctrl_pkg::*;
    logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1, irq;
    logic [1:0] address = 0;
    logic [31:0] writedata = 0, readdata;
    logic [17:0] in_port = 0;
    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] exp_q[$];
    string tag_q[$];

    switch_capture_ctrl #(.WIDTH(18), .TICK_CYCLES(4), .TICK_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .in_port(in_port)
    );

    always #5 clk = ~clk;
    // edges since reset release; tick edges are the multiples of 4
    always @(posedge clk or negedge reset_n) cyc <= !reset_n ? 0 : cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1; write_n = 0;
        step();
        chipselect = 0; write_n = 1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string t);
        logic [31:0] x;
        string s;
        address = a;
        exp_q.push_back(e);
        tag_q.push_back(t);
        step();
        x = exp_q.pop_front();
        s = tag_q.pop_front();
        checks++;
        assert (readdata === x) else begin
            errors++;
            $error("FAIL %s: readdata=%h expected %h", s, readdata, x);
        end
    endtask

    task automatic chk_irq(input logic e, input string t);
        checks++;
        assert (irq === e) else begin
            errors++;
            $error("FAIL %s: irq=%b expected %b", t, irq, e);
        end
    endtask

    task automatic do_reset(input logic [17:0] during, input logic [17:0] after);
        reset_n = 0; chipselect = 0; write_n = 1; address = 0; in_port = during;
        step();
        step();
        reset_n = 1; in_port = after;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        do_reset(0, 0);
        rd(ADDR_DATA, 0, "rst_data");
        rd(ADDR_MASK, 0, "rst_mask");
        rd(ADDR_MODE, 0, "rst_mode");
        rd(ADDR_EDGE, 0, "rst_edge");
        chk_irq(0, "rst_irq");

        // change seen by synchroniser by E2; agreeing ticks E4, E8, commit at E12
        do_reset(0, 18'h5);
        go_to(11);
        rd(ADDR_DATA, 0, "db_2tick");
        rd(ADDR_DATA, 32'h5, "db_3tick");
        rd(ADDR_EDGE, 32'h5, "db_edge");
        chk_irq(0, "db_irq_masked");

        do_reset(0, 0);
        for (int i = 0; i < 40; i++) begin
            in_port[0] = ((i / 3) % 2) == 1;
            step();
        end
        in_port = 0;
        repeat (20) step();
        rd(ADDR_DATA, 0, "bounce_data");
        rd(ADDR_EDGE, 0, "bounce_edge");

        do_reset(0, 18'h1);
        wr(ADDR_MASK, 32'h1);
        go_to(11);
        chk_irq(0, "rise_irq_pre");
        go_to(12);
        chk_irq(1, "rise_irq");
        rd(ADDR_EDGE, 32'h1, "rise_edge");
        wr(ADDR_EDGE, 32'h1);
        chk_irq(0, "rise_clr_irq");
        rd(ADDR_EDGE, 0, "rise_clr_edge");
        wr(ADDR_MODE, 32'h1);
        in_port = 0;
        go_to(27);
        chk_irq(0, "fall_irq_pre");
        go_to(28);
        chk_irq(1, "fall_irq");
        rd(ADDR_EDGE, 32'h1, "fall_edge");
        rd(ADDR_MODE, 32'h1, "fall_mode");
        rd(ADDR_DATA, 0, "fall_data");
        wr(ADDR_MASK, 0);
        chk_irq(0, "mask_off_irq");
        rd(ADDR_EDGE, 32'h1, "mask_off_edge");
        wr(ADDR_EDGE, 32'h1);
        rd(ADDR_EDGE, 0, "fall_clr_edge");

        do_reset(0, 18'h8);
        go_to(11);
        wr(ADDR_EDGE, 32'h8);
        rd(ADDR_EDGE, 32'h8, "collide_edge");
        rd(ADDR_DATA, 32'h8, "collide_data");
        wr(ADDR_EDGE, 32'h8);
        rd(ADDR_EDGE, 0, "collide_clr");

        do_reset(0, 18'h80);
        wr(ADDR_MASK, 32'h80);
        rd(ADDR_MASK, 32'h80, "mid_mask");
        go_to(9);
        reset_n = 0;
        #2;
        checks++;
        assert (readdata === 0) else begin
            errors++;
            $error("FAIL mid_async_rd: readdata=%h expected %h", readdata, 32'h0);
        end
        chk_irq(0, "mid_async_irq");
        do_reset(18'h80, 18'h80);
        rd(ADDR_DATA, 0, "mid_data");
        rd(ADDR_MASK, 0, "mid_mask_clr");
        rd(ADDR_MODE, 0, "mid_mode");
        rd(ADDR_EDGE, 0, "mid_edge");
        go_to(11);
        rd(ADDR_DATA, 0, "mid_recount_2");
        rd(ADDR_DATA, 32'h80, "mid_recount_3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
